// File: rtl/sync_dp_ram_clr_if.sv
// -----------------------------------------------------------------------------
// sync_dp_ram_clr_if
// Bus bundle for the simple-dual-port RAM with clear sequencer.
//   master : drives clear, write port (wr_en/wr_addr/wr_data) and read request
//            (rd_en/rd_addr); observes busy and the read response.
//   slave  : the RAM side; returns busy, rd_data, rd_valid, collision.
// AW is derived from DEPTH so both sides always agree on address width.
// -----------------------------------------------------------------------------
interface sync_dp_ram_clr_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             clear;
  logic             busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             collision;

  modport master (
    output clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid, collision
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid, collision
  );
endinterface

// File: rtl/sync_dp_ram_clr.sv
// -----------------------------------------------------------------------------
// sync_dp_ram_clr
// Parametrised simple-dual-port synchronous RAM (one write port, one read
// port, one clock) with a built-in clear sequencer that writes INIT_VAL to
// every word after reset or on request.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sync_dp_ram_clr_if.slave
//            clear     in  start a full clear (accepted only when idle)
//            busy      out high while the clear sequencer runs
//            wr_en/wr_addr/wr_data  in  write port (out-of-range writes dropped)
//            rd_en/rd_addr          in  read request
//            rd_data   out read data, holds between reads (0 for out-of-range)
//            rd_valid  out one-cycle pulse marking rd_data
//            collision out aligned with rd_valid; read hit the same-cycle write
//
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). READ_MODE
// selects old (0) or new (1) data on a same-address read/write collision.
// -----------------------------------------------------------------------------
module sync_dp_ram_clr #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter int               READ_MODE = 0,
  parameter int               OUT_REG   = 0,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_dp_ram_clr_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  // One extra bit so the range compare also works when DEPTH is a power of 2.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e           r_state, w_state_nxt;
  logic [AW-1:0]    r_ptr, w_ptr_nxt;

  logic             w_idle;
  logic             w_wr_ok;
  logic             w_rd_fire;
  logic             w_rd_in_range;
  logic             w_coll;
  logic [WIDTH-1:0] w_rd_word;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             r_rd_valid;
  logic             r_rd_coll;
  logic [WIDTH-1:0] r_rd_data;

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output
    // unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (r_ptr == LAST_PTR) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  assign w_idle   = (r_state == ST_IDLE);
  assign bus.busy = (r_state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Port qualification: both user ports are dead while clearing.
  // ---------------------------------------------------------------------------
  assign w_wr_ok       = w_idle && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
  assign w_rd_fire     = w_idle && bus.rd_en;
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
  // w_wr_ok already implies an in-range address, so equality covers the read.
  assign w_coll        = w_wr_ok && w_rd_fire && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      // mem still holds pre-write contents here, giving read-first naturally.
      if (READ_MODE == 1 && w_coll) w_rd_word = bus.wr_data;
      else                          w_rd_word = mem[bus.rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. The sequencer owns the write port while clearing.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset on every word would prevent RAM
  // inference. The clear sequencer provides the defined initial contents.
  always_ff @(posedge clk) begin
    if (!w_idle)      mem[r_ptr]       <= INIT_VAL;
    else if (w_wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

  // ---------------------------------------------------------------------------
  // Read stage 1 (always present)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_coll  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_rd_coll  <= w_rd_fire && w_coll;
      if (w_rd_fire) r_rd_data <= w_rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output stage
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic             r_out_valid;
    logic             r_out_coll;
    logic [WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_coll  <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_rd_valid;
        r_out_coll  <= r_rd_coll;
        if (r_rd_valid) r_out_data <= r_rd_data;
      end
    end

    assign bus.rd_valid  = r_out_valid;
    assign bus.collision = r_out_coll;
    assign bus.rd_data   = r_out_data;
  end else begin : g_no_out_reg
    assign bus.rd_valid  = r_rd_valid;
    assign bus.collision = r_rd_coll;
    assign bus.rd_data   = r_rd_data;
  end

endmodule

// File: tb/tb_sync_dp_ram_clr.sv
// -----------------------------------------------------------------------------
// tb_sync_dp_ram_clr
// Two instances share one directed stimulus stream:
//   u_dut_a : DEPTH=16, READ_MODE=0 (read-first),  OUT_REG=0 (1-cycle latency)
//   u_dut_b : DEPTH=12, READ_MODE=1 (write-first), OUT_REG=1 (2-cycle latency)
// Both use WIDTH=8, INIT_VAL=8'hA5 and share AW=4, so out-of-range addresses
// 12..15 are legal for A and dropped/zero for B. Each read pushes a
// hand-computed expectation per instance; a negedge monitor checks rd_valid
// timing, data, collision and rd_data hold every cycle.
// -----------------------------------------------------------------------------
module tb_sync_dp_ram_clr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sync_dp_ram_clr_if #(.WIDTH(8), .DEPTH(16)) if_a ();
  sync_dp_ram_clr_if #(.WIDTH(8), .DEPTH(12)) if_b ();

  sync_dp_ram_clr #(
    .WIDTH(8), .DEPTH(16), .READ_MODE(0), .OUT_REG(0), .INIT_VAL(8'hA5)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  sync_dp_ram_clr #(
    .WIDTH(8), .DEPTH(12), .READ_MODE(1), .OUT_REG(1), .INIT_VAL(8'hA5)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       coll;
    int         cyc;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_a = '0;
  logic [7:0] last_b = '0;

  // Monitor A: 1-cycle latency
  always @(negedge clk) begin : mon_a
    logic exp_v;
    exp_t e;
    if (!rst_n) last_a = '0;
    exp_v = (q_a.size() > 0) && (q_a[0].cyc + 1 == cyc);
    check("a_valid", if_a.rd_valid, exp_v);
    if (exp_v) begin
      e = q_a.pop_front();
      check("a_data", if_a.rd_data, e.data);
      check("a_coll", if_a.collision, e.coll);
      last_a = e.data;
    end else begin
      check("a_hold", if_a.rd_data, last_a);
      check("a_coll_idle", if_a.collision, 1'b0);
    end
  end

  // Monitor B: 2-cycle latency
  always @(negedge clk) begin : mon_b
    logic exp_v;
    exp_t e;
    if (!rst_n) last_b = '0;
    exp_v = (q_b.size() > 0) && (q_b[0].cyc + 2 == cyc);
    check("b_valid", if_b.rd_valid, exp_v);
    if (exp_v) begin
      e = q_b.pop_front();
      check("b_data", if_b.rd_data, e.data);
      check("b_coll", if_b.collision, e.coll);
      last_b = e.data;
    end else begin
      check("b_hold", if_b.rd_data, last_b);
      check("b_coll_idle", if_b.collision, 1'b0);
    end
  end

  task automatic idle();
    if_a.clear = 1'b0; if_a.wr_en = 1'b0; if_a.rd_en = 1'b0;
    if_b.clear = 1'b0; if_b.wr_en = 1'b0; if_b.rd_en = 1'b0;
  endtask

  // One cycle of stimulus on both instances, then advance to the next negedge.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [7:0] ea, input logic ca,
                       input logic [7:0] eb, input logic cb);
    if_a.wr_en = we; if_a.wr_addr = wa; if_a.wr_data = wd;
    if_a.rd_en = re; if_a.rd_addr = ra;
    if_b.wr_en = we; if_b.wr_addr = wa; if_b.wr_data = wd;
    if_b.rd_en = re; if_b.rd_addr = ra;
    if (re) begin
      q_a.push_back('{ea, ca, cyc});
      q_b.push_back('{eb, cb, cyc});
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ea, input logic [7:0] eb);
    drive(1'b0, 4'd0, 8'h00, 1'b1, a, ea, 1'b0, eb, 1'b0);
  endtask

  // Count negedges with busy high per instance; with hold set, wr_en/rd_en are
  // held high on each instance for every cycle it is still busy.
  task automatic measure_busy(input logic hold, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (if_a.busy) na++;
      if (if_b.busy) nb++;
      if (!if_a.busy && !if_b.busy) break;
      if_a.wr_en = hold & if_a.busy; if_a.rd_en = hold & if_a.busy;
      if_b.wr_en = hold & if_b.busy; if_b.rd_en = hold & if_b.busy;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy_a"},  if_a.busy,      1'b1);
    check({tag, "_busy_b"},  if_b.busy,      1'b1);
    check({tag, "_valid_a"}, if_a.rd_valid,  1'b0);
    check({tag, "_valid_b"}, if_b.rd_valid,  1'b0);
    check({tag, "_data_a"},  if_a.rd_data,   8'h00);
    check({tag, "_data_b"},  if_b.rd_data,   8'h00);
    check({tag, "_coll_a"},  if_a.collision, 1'b0);
    check({tag, "_coll_b"},  if_b.collision, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         na, nb;
    logic [7:0] ea, eb;

    rst_n = 1'b0;
    idle();
    if_a.wr_addr = '0; if_a.wr_data = '0; if_a.rd_addr = '0;
    if_b.wr_addr = '0; if_b.wr_data = '0; if_b.rd_addr = '0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. busy length after reset, then every word reads INIT_VAL
    measure_busy(1'b0, na, nb);
    check("busy_len_rst_a", na, 16);
    check("busy_len_rst_b", nb, 12);
    for (int k = 0; k < 16; k++) rd(4'(k), 8'hA5, (k < 12) ? 8'hA5 : 8'h00);

    // 2. write k to k, back-to-back readback
    for (int k = 0; k < 16; k++) wr(4'(k), 8'(k));
    for (int k = 0; k < 16; k++) rd(4'(k), 8'(k), (k < 12) ? 8'(k) : 8'h00);

    // 3. same-address collision: A read-first, B write-first
    wr(4'd5, 8'h3C);
    drive(1'b1, 4'd5, 8'hC3, 1'b1, 4'd5, 8'h3C, 1'b1, 8'hC3, 1'b1);
    rd(4'd5, 8'hC3, 8'hC3);

    // 4. address 13/14: in range for A, out of range for B
    wr(4'd13, 8'hFF);
    rd(4'd13, 8'hFF, 8'h00);
    drive(1'b1, 4'd14, 8'h5E, 1'b1, 4'd14, 8'h0E, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 16; k++) begin
      ea = 8'(k);
      if (k == 5)  ea = 8'hC3;
      if (k == 13) ea = 8'hFF;
      if (k == 14) ea = 8'h5E;
      eb = (k < 12) ? ((k == 5) ? 8'hC3 : 8'(k)) : 8'h00;
      rd(4'(k), ea, eb);
    end
    idle();
    repeat (3) @(negedge clk);

    // 5. clear accepted together with a read; strobes held high while busy
    if_a.clear = 1'b1;
    if_b.clear = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'hC3, 1'b0, 8'hC3, 1'b0);
    if_a.clear = 1'b0;
    if_b.clear = 1'b0;
    if_a.wr_addr = 4'd3; if_a.wr_data = 8'h77; if_a.rd_addr = 4'd3;
    if_b.wr_addr = 4'd3; if_b.wr_data = 8'h77; if_b.rd_addr = 4'd3;
    measure_busy(1'b1, na, nb);
    check("busy_len_clr_a", na, 16);
    check("busy_len_clr_b", nb, 12);
    for (int k = 0; k < 16; k++) rd(4'(k), 8'hA5, (k < 12) ? 8'hA5 : 8'h00);
    idle();
    repeat (3) @(negedge clk);

    // 6. reset in the middle of a clear sequence
    if_a.clear = 1'b1;
    if_b.clear = 1'b1;
    @(negedge clk);
    idle();
    repeat (6) @(negedge clk);
    check("midclr_busy_a", if_a.busy, 1'b1);
    check("midclr_busy_b", if_b.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(1'b0, na, nb);
    check("busy_len_rst2_a", na, 16);
    check("busy_len_rst2_b", nb, 12);
    rd(4'd3,  8'hA5, 8'hA5);
    rd(4'd13, 8'hA5, 8'h00);
    idle();
    repeat (4) @(negedge clk);

    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_dp_ram_clr.md
Name: sync_dp_ram_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. It generalises the team's 16x8 asynchronous single-port memory in these ways:
- width and depth are parameters;
- write and read ports are separate, with no tri-state data bus;
- reads are registered, with a valid strobe and optional output pipeline stage;
- same-address collision behaviour is selectable;
- a built-in clear sequencer initialises every location after reset or on request.

It is the storage primitive for buffers and register files in later blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 16, number of words (>=2, need not be a power of 2).
READ_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new data).
OUT_REG, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency).
INIT_VAL, 0, WIDTH-bit value written to every location by the clear sequencer.
(localparam AW = $clog2(DEPTH))

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  request a full memory clear; sampled only in IDLE.
busy  out  1  high while the clear sequencer runs.
wr_en  in  1  write strobe.
wr_addr  in  AW  write address.
wr_data  in  WIDTH  write data.
rd_en  in  1  read strobe.
rd_addr  in  AW  read address.
rd_data  out  WIDTH  read data; holds its last value between reads.
rd_valid  out  1  one-cycle pulse marking rd_data valid.
collision  out  1  pulse aligned with rd_valid; the read hit the address written in the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to CLEAR with clear pointer = 0.
  - busy=1, rd_data=0, rd_valid=0, collision=0, all pipeline valids=0.
  - Memory array is not reset directly; the clear sequencer initialises it.
- FSM states: CLEAR and IDLE.
  - CLEAR: each clk writes INIT_VAL to mem[ptr], then ptr++. After writing DEPTH-1 the FSM moves to IDLE and busy falls. busy is therefore high for exactly DEPTH cycles after reset release.
  - IDLE: clear=1 moves the FSM to CLEAR with ptr=0, and busy=1 from the next edge. clear is ignored while in CLEAR.
- While busy=1: wr_en and rd_en are ignored; no user writes, no rd_valid.
- Write: wr_en=1 in IDLE gives mem[wr_addr] <= wr_data at the edge. If wr_addr >= DEPTH, the write is dropped.
- Read latency:
  - OUT_REG=0: rd_en=1 sampled at edge N; rd_data/rd_valid are updated at edge N and visible in the following cycle.
  - OUT_REG=1: rd_data/rd_valid appear one edge later.
  - Back-to-back reads give one result per cycle, in order.
  - rd_addr >= DEPTH returns 0 with rd_valid=1.
- Collision: wr_en && rd_en && wr_addr==rd_addr, both in range, in IDLE.
  - READ_MODE=0 returns the pre-write contents; READ_MODE=1 returns wr_data.
  - collision=1 in the same cycle as the matching rd_valid.
- clear accepted with rd_en in the same IDLE cycle: the read completes normally (old data). Reads still in the pipeline when busy rises also complete.
- Reset mid-clear or mid-read: the pipeline is flushed (rd_valid=0) and the clear sequence restarts from address 0.

Test Plan:
1. Reset release, WIDTH=8, DEPTH=16, INIT_VAL=8'hA5 -> busy high for exactly 16 cycles; reads of addresses 0..15 then all return 8'hA5 with rd_valid pulses.
2. Write k to address k for k=0..15, then read back 0..15 on consecutive cycles -> rd_data=0..15 in order; latency 1 cycle (OUT_REG=0) and 2 cycles (OUT_REG=1).
3. Write 8'h3C to address 5, then in one cycle write 8'hC3 and read address 5 -> READ_MODE=0 returns 8'h3C, READ_MODE=1 returns 8'hC3; collision=1 in both cases.
4. DEPTH=12: write 8'hFF to address 13, read address 13 -> write dropped, rd_data=0, rd_valid=1; locations 0..11 unchanged.
5. Pulse clear in IDLE after filling memory -> busy=1 for 16 cycles; wr_en/rd_en held high during busy have no effect (no rd_valid); afterwards all locations read INIT_VAL.
6. Assert rst_n=0 at cycle 7 of a clear sequence -> outputs zero immediately; after release busy lasts a full 16 cycles.
